tdc_selftest_seq: RTL and testbench

Self-test sequencer for the TDC front end. On a command from the microcontroller it produces a programmable number of start/stop test-pulse pairs with a programmable start-to-stop spacing. After each stop it waits for the TDC to report a finished measurement, with a timeout. The block sits between the uC register interface and the TDC test-pulse injection path, and replaces the free-running test counter as the source of `tst_start_pulse`/`tst_stop_pulse`.

---
 rtl/tdc_selftest_seq.sv | 211 +++++++++++++++++++++
 tb/tb_tdc_selftest_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_selftest_seq.sv
// ============================================================================
// tdc_selftest_seq : start/stop test-pulse sequencer for the TDC self-test
// Rev 1.0
// ============================================================================
`default_nettype none

module tdc_selftest_seq #(
    parameter int unsigned INIT_DLY = 800000,
    parameter int unsigned TIMEOUT  = 4095,
    parameter int unsigned GAP_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_cmd,
    input  logic             abort,
    input  logic [7:0]       num_pairs,
    input  logic [GAP_W-1:0] gap,
    input  logic [15:0]      period,
    input  logic             meas_done,
    output logic             tst_start_pulse,
    output logic             tst_stop_pulse,
    output logic             testing,
    output logic             done,
    output logic             err_timeout,
    output logic [7:0]       pair_cnt
);

    // One shared counter serves every timed state; it only ever counts up to
    // the limit of the state it is in, so it never wraps.
    localparam int unsigned CNT_W = (GAP_W > 20) ? GAP_W : 20;
    localparam logic [CNT_W-1:0] ARM_LAST = (INIT_DLY == 0) ? '0 : CNT_W'(INIT_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT == 0)  ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_START  = 3'd2,
        ST_GAP    = 3'd3,
        ST_STOP   = 3'd4,
        ST_WAIT   = 3'd5,
        ST_PERIOD = 3'd6,
        ST_FINISH = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       num_q, num_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      period_q, period_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             testing_q, testing_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       pair_q, pair_d;

    logic [CNT_W-1:0] gap_last;
    logic [CNT_W-1:0] period_last;
    logic [7:0]       pair_inc;

    assign gap_last    = CNT_W'(gap_q - GAP_W'(1));
    assign period_last = CNT_W'(period_q - 16'd1);
    assign pair_inc    = pair_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        gap_d     = gap_q;
        period_d  = period_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        testing_d = testing_q;
        done_d    = 1'b0;
        err_d     = err_q;
        pair_d    = pair_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            testing_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_cmd && !abort) begin
                        num_d     = num_pairs;
                        gap_d     = (gap == '0) ? GAP_W'(1) : gap;
                        period_d  = period;
                        pair_d    = 8'd0;
                        err_d     = 1'b0;
                        testing_d = 1'b1;
                        cnt_d     = '0;
                        if (num_pairs == 8'd0) begin
                            state_d = ST_FINISH;
                            done_d  = 1'b1;
                        end else if (INIT_DLY == 0) begin
                            state_d = ST_START;
                            start_d = 1'b1;
                        end else begin
                            state_d = ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (cnt_q == ARM_LAST) begin
                        state_d = ST_START;
                        start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_START: begin
                    cnt_d = CNT_W'(1);
                    if (gap_q == GAP_W'(1)) begin
                        state_d = ST_STOP;
                        stop_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == gap_last) begin
                        state_d = ST_STOP;
                        stop_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
                ST_WAIT: begin
                    // A measurement arriving on the timeout cycle still counts.
                    if (meas_done) begin
                        pair_d = pair_inc;
                        cnt_d  = '0;
                        if (pair_inc == num_q) begin
                            state_d = ST_FINISH;
                            done_d  = 1'b1;
                        end else if (period_q == 16'd0) begin
                            state_d = ST_START;
                            start_d = 1'b1;
                        end else begin
                            state_d = ST_PERIOD;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_PERIOD: begin
                    if (cnt_q == period_last) begin
                        state_d = ST_START;
                        start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_FINISH: begin
                    state_d   = ST_IDLE;
                    testing_d = 1'b0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    testing_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            gap_q     <= '0;
            period_q  <= '0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            testing_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pair_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            gap_q     <= gap_d;
            period_q  <= period_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            testing_q <= testing_d;
            done_q    <= done_d;
            err_q     <= err_d;
            pair_q    <= pair_d;
        end
    end

    assign tst_start_pulse = start_q;
    assign tst_stop_pulse  = stop_q;
    assign testing         = testing_q;
    assign done            = done_q;
    assign err_timeout     = err_q;
    assign pair_cnt        = pair_q;

endmodule

`default_nettype wire

// File: tb/tb_tdc_selftest_seq.sv
// ============================================================================
// tb_tdc_selftest_seq : bench for tdc_selftest_seq against an event-time model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_tdc_selftest_seq;

    localparam int INIT_DLY = 10;
    localparam int TIMEOUT  = 60;
    localparam int GAP_W    = 16;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic             start_cmd = 1'b0;
    logic             abort     = 1'b0;
    logic             meas_done = 1'b0;
    logic [7:0]       num_pairs = '0;
    logic [GAP_W-1:0] gap       = '0;
    logic [15:0]      period    = '0;
    logic             tst_start_pulse, tst_stop_pulse, testing, done, err_timeout;
    logic [7:0]       pair_cnt;

    int total = 0;
    int bad   = 0;

    tdc_selftest_seq #(.INIT_DLY(INIT_DLY), .TIMEOUT(TIMEOUT), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset_n(reset_n), .start_cmd(start_cmd), .abort(abort),
        .num_pairs(num_pairs), .gap(gap), .period(period), .meas_done(meas_done),
        .tst_start_pulse(tst_start_pulse), .tst_stop_pulse(tst_stop_pulse),
        .testing(testing), .done(done), .err_timeout(err_timeout), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    // Cycle k is the interval following the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus knobs and model results
    int dly[0:7];
    int abort_at = -1;
    bit spur_md  = 1'b0;
    bit rep_cmd  = 1'b0;
    int exp_start[$], exp_stop[$], exp_done[$], md_list[$];
    int exp_pairs, exp_err, exp_err_first, exp_t_first, exp_t_last, end_cyc;
    bit md_sched[int];
    bit stop_sched[int];

    // Observations
    int run_a = 32'h3fff_ffff;
    int obs_start[$], obs_stop[$], obs_done[$];
    int obs_t_first, obs_t_last, obs_t_cnt, obs_err_first;
    logic obs_err_a1;

    always @(negedge clk) begin
        if (cyc > run_a) begin
            if (tst_start_pulse) obs_start.push_back(cyc);
            if (tst_stop_pulse)  obs_stop.push_back(cyc);
            if (done)            obs_done.push_back(cyc);
            if (testing) begin
                if (obs_t_first < 0) obs_t_first = cyc;
                obs_t_last = cyc;
                obs_t_cnt++;
            end
            if (err_timeout && obs_err_first < 0) obs_err_first = cyc;
            if (cyc == run_a + 1) obs_err_a1 = err_timeout;
        end
    end

    function automatic int first_diff(input int a[$], input int b[$]);
        int n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic int qhead(input int a[$]);
        return (a.size() > 0) ? a[0] : -1;
    endfunction

    // Event-time model: each pulse time follows from the previous one by the
    // stated latencies; an abort then truncates everything after its cycle.
    function automatic void model(input int a, input int n, input int g, input int per);
        int s, p, m, ge;
        int q[$];
        exp_start = {}; exp_stop = {}; exp_done = {}; md_list = {};
        md_sched.delete(); stop_sched.delete();
        exp_pairs = 0; exp_err = 0; exp_err_first = -1;
        ge = (g == 0) ? 1 : g;
        exp_t_first = a + 1;
        exp_t_last  = a + 1;
        if (n == 0) begin
            exp_done.push_back(a + 1);
        end else begin
            s = a + 1 + INIT_DLY;
            for (int i = 0; i < n; i++) begin
                exp_start.push_back(s);
                p = s + ge;
                exp_stop.push_back(p);
                if (dly[i] >= 1 && dly[i] <= TIMEOUT) begin
                    m = p + dly[i];
                    md_list.push_back(m);
                    exp_pairs++;
                    if (i == n - 1) begin
                        exp_done.push_back(m + 1);
                        exp_t_last = m + 1;
                    end else begin
                        s = m + 1 + per;
                    end
                end else begin
                    exp_err = 1;
                    exp_err_first = p + TIMEOUT + 1;
                    exp_done.push_back(p + TIMEOUT + 1);
                    exp_t_last = p + TIMEOUT + 1;
                    break;
                end
            end
        end
        if (abort_at >= 0) begin
            q = {}; foreach (exp_start[i]) if (exp_start[i] <= abort_at) q.push_back(exp_start[i]);
            exp_start = q;
            q = {}; foreach (exp_stop[i]) if (exp_stop[i] <= abort_at) q.push_back(exp_stop[i]);
            exp_stop = q;
            q = {}; foreach (exp_done[i]) if (exp_done[i] <= abort_at) q.push_back(exp_done[i]);
            exp_done = q;
            q = {}; foreach (md_list[i]) if (md_list[i] < abort_at) q.push_back(md_list[i]);
            md_list = q;
            exp_pairs = md_list.size();
            if (exp_t_last > abort_at) exp_t_last = abort_at;
            if (exp_err_first > abort_at) begin exp_err = 0; exp_err_first = -1; end
        end
        foreach (md_list[i])  md_sched[md_list[i]] = 1'b1;
        foreach (exp_stop[i]) stop_sched[exp_stop[i]] = 1'b1;
        end_cyc = exp_t_last + 4;
    endfunction

    task automatic begin_run(input int n, input int g, input int per);
        @(negedge clk); #1;
        run_a = cyc;
        obs_start = {}; obs_stop = {}; obs_done = {};
        obs_t_first = -1; obs_t_last = -1; obs_t_cnt = 0; obs_err_first = -1; obs_err_a1 = 1'bx;
        model(run_a, n, g, per);
        num_pairs = n[7:0]; gap = g[GAP_W-1:0]; period = per[15:0];
        start_cmd = 1'b1;
    endtask

    task automatic run_seq(input int n, input int g, input int per);
        begin_run(n, g, per);
        while (cyc < end_cyc) begin
            @(negedge clk); #1;
            start_cmd = rep_cmd && (stop_sched.exists(cyc) || cyc == run_a + 2);
            meas_done = md_sched.exists(cyc) || (spur_md && stop_sched.exists(cyc));
            abort     = (cyc == abort_at);
            num_pairs = 8'($urandom);
            gap       = GAP_W'($urandom);
            period    = 16'($urandom);
        end
        start_cmd = 1'b0; meas_done = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({tst_start_pulse, tst_stop_pulse, testing, done, err_timeout, pair_cnt} !== 13'd0) begin
            bad++; $display("FAIL reset_held: got %b want 0", {tst_start_pulse, tst_stop_pulse, testing, done, err_timeout, pair_cnt});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({tst_start_pulse, tst_stop_pulse, testing, done, err_timeout, pair_cnt} !== 13'd0) begin
            bad++; $display("FAIL reset_idle: got %b want 0", {tst_start_pulse, tst_stop_pulse, testing, done, err_timeout, pair_cnt});
        end
    endtask

    task automatic test_basic();
        abort_at = -1; spur_md = 0; rep_cmd = 0;
        for (int i = 0; i < 3; i++) dly[i] = 20;
        run_seq(3, 400, 5);
        total++;
        if (first_diff(obs_start, exp_start) != -1) begin
            bad++; $display("FAIL basic_start: got n=%0d first=%0d want n=%0d first=%0d", obs_start.size(), qhead(obs_start), exp_start.size(), qhead(exp_start));
        end
        total++;
        if (first_diff(obs_stop, exp_stop) != -1) begin
            bad++; $display("FAIL basic_stop: got n=%0d first=%0d want n=%0d first=%0d", obs_stop.size(), qhead(obs_stop), exp_stop.size(), qhead(exp_stop));
        end
        total++;
        if (first_diff(obs_done, exp_done) != -1) begin
            bad++; $display("FAIL basic_done: got n=%0d at %0d want n=%0d at %0d", obs_done.size(), qhead(obs_done), exp_done.size(), qhead(exp_done));
        end
        total++;
        if (pair_cnt !== 8'd3) begin bad++; $display("FAIL basic_pairs: got %0d want 3", pair_cnt); end
        total++;
        if (err_timeout !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err_timeout); end
        total++;
        if (obs_t_first != exp_t_first || obs_t_last != exp_t_last || obs_t_cnt != exp_t_last - exp_t_first + 1) begin
            bad++; $display("FAIL basic_testing: got %0d..%0d (%0d) want %0d..%0d", obs_t_first, obs_t_last, obs_t_cnt, exp_t_first, exp_t_last);
        end
    endtask

    task automatic test_gap_zero();
        abort_at = -1; spur_md = 0; rep_cmd = 0;
        dly[0] = 7;
        run_seq(1, 0, 0);
        total++;
        if (obs_start.size() != 1 || obs_stop.size() != 1 || obs_stop[0] != obs_start[0] + 1) begin
            bad++; $display("FAIL gap0_spacing: got start=%0d stop=%0d want stop=start+1", qhead(obs_start), qhead(obs_stop));
        end
        total++;
        if (first_diff(obs_done, exp_done) != -1) begin
            bad++; $display("FAIL gap0_done: got %0d want %0d", qhead(obs_done), qhead(exp_done));
        end
        total++;
        if (pair_cnt !== 8'd1) begin bad++; $display("FAIL gap0_pairs: got %0d want 1", pair_cnt); end
    endtask

    task automatic test_timeout();
        abort_at = -1; spur_md = 0; rep_cmd = 0;
        dly[0] = -1; dly[1] = -1;
        run_seq(2, 12, 3);
        total++;
        if (obs_start.size() != 1) begin bad++; $display("FAIL to_starts: got %0d want 1", obs_start.size()); end
        total++;
        if (obs_err_first != exp_err_first) begin
            bad++; $display("FAIL to_err_time: got %0d want %0d", obs_err_first, exp_err_first);
        end
        total++;
        if (first_diff(obs_done, exp_done) != -1) begin
            bad++; $display("FAIL to_done: got %0d want %0d", qhead(obs_done), qhead(exp_done));
        end
        total++;
        if (pair_cnt !== 8'd0) begin bad++; $display("FAIL to_pairs: got %0d want 0", pair_cnt); end
        total++;
        if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
        // The next accepted command clears the sticky error.
        dly[0] = 3;
        run_seq(1, 2, 0);
        total++;
        if (obs_err_a1 !== 1'b0 || err_timeout !== 1'b0) begin
            bad++; $display("FAIL to_clear: got %b/%b want 0/0", obs_err_a1, err_timeout);
        end
    endtask

    task automatic test_abort();
        spur_md = 0; rep_cmd = 0;
        for (int i = 0; i < 3; i++) dly[i] = 10;
        abort_at = -1;
        model(0, 3, 50, 4);
        abort_at = exp_start[1] + 10 + (cyc + 1) - 0;
        // Re-anchor: run_seq anchors the model at the next cycle, so compute
        // the abort cycle relative to that anchor.
        @(negedge clk);
        abort_at = -1;
        model(cyc + 1, 3, 50, 4);
        abort_at = exp_start[1] + 10;
        run_seq(3, 50, 4);
        total++;
        if (obs_stop.size() != 1) begin bad++; $display("FAIL abort_stops: got %0d want 1", obs_stop.size()); end
        total++;
        if (obs_start.size() != 2) begin bad++; $display("FAIL abort_starts: got %0d want 2", obs_start.size()); end
        total++;
        if (obs_done.size() != 0) begin bad++; $display("FAIL abort_done: got %0d pulses want 0", obs_done.size()); end
        total++;
        if (obs_t_last != abort_at) begin bad++; $display("FAIL abort_testing: got last=%0d want %0d", obs_t_last, abort_at); end
        total++;
        if (pair_cnt !== 8'd1) begin bad++; $display("FAIL abort_pairs: got %0d want 1", pair_cnt); end
        abort_at = -1;
    endtask

    task automatic test_num_zero();
        abort_at = -1; spur_md = 0; rep_cmd = 0;
        run_seq(0, 5, 5);
        total++;
        if (first_diff(obs_done, exp_done) != -1) begin
            bad++; $display("FAIL zero_done: got n=%0d at %0d want at %0d", obs_done.size(), qhead(obs_done), qhead(exp_done));
        end
        total++;
        if (obs_t_first != exp_t_first || obs_t_cnt != 1) begin
            bad++; $display("FAIL zero_testing: got first=%0d cnt=%0d want first=%0d cnt=1", obs_t_first, obs_t_cnt, exp_t_first);
        end
        total++;
        if (obs_start.size() != 0) begin bad++; $display("FAIL zero_starts: got %0d want 0", obs_start.size()); end
    endtask

    task automatic test_random();
        int n, g, per;
        abort_at = -1;
        for (int it = 0; it < 6; it++) begin
            n   = $urandom_range(1, 4);
            g   = $urandom_range(0, 30);
            per = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) begin
                dly[i] = $urandom_range(1, TIMEOUT);
                if ($urandom_range(0, 7) == 0) dly[i] = TIMEOUT;
                if ($urandom_range(0, 11) == 0) dly[i] = -1;
            end
            spur_md = 1'($urandom_range(0, 1));
            rep_cmd = 1'($urandom_range(0, 1));
            run_seq(n, g, per);
            total++;
            if (first_diff(obs_start, exp_start) != -1 || first_diff(obs_stop, exp_stop) != -1) begin
                bad++; $display("FAIL rand%0d_pulses: got starts=%0d stops=%0d want starts=%0d stops=%0d", it, obs_start.size(), obs_stop.size(), exp_start.size(), exp_stop.size());
            end
            total++;
            if (first_diff(obs_done, exp_done) != -1) begin
                bad++; $display("FAIL rand%0d_done: got %0d want %0d", it, qhead(obs_done), qhead(exp_done));
            end
            total++;
            if (pair_cnt !== 8'(exp_pairs)) begin bad++; $display("FAIL rand%0d_pairs: got %0d want %0d", it, pair_cnt, exp_pairs); end
            total++;
            if (err_timeout !== 1'(exp_err) || obs_err_first != exp_err_first) begin
                bad++; $display("FAIL rand%0d_err: got %b at %0d want %0d at %0d", it, err_timeout, obs_err_first, exp_err, exp_err_first);
            end
            total++;
            if (obs_t_first != exp_t_first || obs_t_last != exp_t_last || obs_t_cnt != exp_t_last - exp_t_first + 1) begin
                bad++; $display("FAIL rand%0d_testing: got %0d..%0d want %0d..%0d", it, obs_t_first, obs_t_last, exp_t_first, exp_t_last);
            end
        end
        spur_md = 0; rep_cmd = 0;
    endtask

    task automatic test_reset_mid();
        int tgt;
        abort_at = -1; spur_md = 0; rep_cmd = 0;
        dly[0] = -1; dly[1] = -1;
        begin_run(2, 5, 3);
        tgt = exp_stop[0] + 3;
        while (cyc < tgt) begin
            @(negedge clk); #1;
            start_cmd = 1'b0;
        end
        total++;
        if (testing !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got testing=%b want 1", testing); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({tst_start_pulse, tst_stop_pulse, testing, done, err_timeout, pair_cnt} !== 13'd0) begin
            bad++; $display("FAIL rstmid_async: got %b want 0", {tst_start_pulse, tst_stop_pulse, testing, done, err_timeout, pair_cnt});
        end
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        dly[0] = 4; dly[1] = 7;
        run_seq(2, 3, 2);
        total++;
        if (first_diff(obs_start, exp_start) != -1 || first_diff(obs_done, exp_done) != -1) begin
            bad++; $display("FAIL rstmid_rerun: got start=%0d done=%0d want start=%0d done=%0d", qhead(obs_start), qhead(obs_done), qhead(exp_start), qhead(exp_done));
        end
        total++;
        if (pair_cnt !== 8'd2) begin bad++; $display("FAIL rstmid_pairs: got %0d want 2", pair_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) dly[i] = 1;
        test_reset();
        test_basic();
        test_gap_zero();
        test_timeout();
        test_abort();
        test_num_zero();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
